button_conditioner: RTL and testbench

- Conditions the three raw push-button inputs (mode, inc, zero) before they reach the watch top level.
- Per button: 2-flop synchroniser, counter-based debouncer, one-cycle press-pulse generator.
- Buttons selected by REPEAT_MASK also auto-repeat while held. By default only inc repeats, so a held inc steps the time or alarm value continuously.
- Sits between the board pins and the clock top level. The top level consumes btn_pulse in place of the raw button wires.

---
 rtl/button_conditioner.sv | 152 +++++++++++++++
 tb/tb_button_conditioner.sv | 130 +++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: per-button 2-flop synchroniser, counter debouncer and
// one-cycle press pulse, with auto-repeat pulses for buttons held down.
module button_conditioner #(
  parameter int unsigned         NUM_BTN         = 3,
  parameter int unsigned         DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned         REPEAT_DELAY    = 50000000,
  parameter int unsigned         REPEAT_PERIOD   = 10000000,
  parameter logic [NUM_BTN-1:0]  REPEAT_MASK     = 3'b010,
  parameter int unsigned         CNT_W           = 26
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HOLD    = 2'd2,
    ST_REPEAT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_BTN-1:0] r_s1;
  logic [NUM_BTN-1:0] r_s2;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_pulse;
  logic [NUM_BTN-1:0] w_level_nxt;
  logic [NUM_BTN-1:0] w_pulse_nxt;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_fall;

  logic [CNT_W-1:0] r_dcnt     [NUM_BTN];
  logic [CNT_W-1:0] w_dcnt_nxt [NUM_BTN];
  logic [CNT_W-1:0] r_hcnt     [NUM_BTN];
  logic [CNT_W-1:0] w_hcnt_nxt [NUM_BTN];
  state_t           r_state    [NUM_BTN];
  state_t           w_state_nxt[NUM_BTN];

  // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    w_level_nxt = r_level;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      w_dcnt_nxt[i] = r_dcnt[i];
      if (r_s2[i] == r_level[i]) begin
        w_dcnt_nxt[i] = {CNT_W{1'b0}};
      end else if (r_dcnt[i] == DEB_LAST) begin
        w_level_nxt[i] = r_s2[i];
        w_dcnt_nxt[i]  = {CNT_W{1'b0}};
      end else begin
        w_dcnt_nxt[i] = r_dcnt[i] + CNT_ONE;
      end
    end
  end

  // Edges are taken from the next level so the pulse lines up with the level change
  assign w_rise = w_level_nxt & ~r_level;
  assign w_fall = ~w_level_nxt & r_level;

  // Press/repeat FSM per button; a release always wins over a coinciding repeat tick
  always_comb begin
    w_pulse_nxt = {NUM_BTN{1'b0}};
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      w_state_nxt[i] = r_state[i];
      w_hcnt_nxt[i]  = r_hcnt[i];
      case (r_state[i])
        ST_IDLE: begin
          if (w_rise[i]) begin
            w_pulse_nxt[i] = 1'b1;
            if (REPEAT_MASK[i]) begin
              w_hcnt_nxt[i]  = {CNT_W{1'b0}};
              w_state_nxt[i] = ST_HOLD;
            end else begin
              w_state_nxt[i] = ST_PRESSED;
            end
          end else begin
            w_state_nxt[i] = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (w_fall[i]) begin
            w_state_nxt[i] = ST_IDLE;
          end else begin
            w_state_nxt[i] = ST_PRESSED;
          end
        end
        ST_HOLD: begin
          if (w_fall[i]) begin
            w_hcnt_nxt[i]  = {CNT_W{1'b0}};
            w_state_nxt[i] = ST_IDLE;
          end else if (r_hcnt[i] == DLY_LAST) begin
            w_pulse_nxt[i] = 1'b1;
            w_hcnt_nxt[i]  = {CNT_W{1'b0}};
            w_state_nxt[i] = ST_REPEAT;
          end else begin
            w_hcnt_nxt[i] = r_hcnt[i] + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (w_fall[i]) begin
            w_hcnt_nxt[i]  = {CNT_W{1'b0}};
            w_state_nxt[i] = ST_IDLE;
          end else if (r_hcnt[i] == PER_LAST) begin
            w_pulse_nxt[i] = 1'b1;
            w_hcnt_nxt[i]  = {CNT_W{1'b0}};
          end else begin
            w_hcnt_nxt[i] = r_hcnt[i] + CNT_ONE;
          end
        end
        default: begin
          w_hcnt_nxt[i]  = {CNT_W{1'b0}};
          w_state_nxt[i] = ST_IDLE;
        end
      endcase
    end
  end

  // State registers; clr clears everything asynchronously, aborting any repeat
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_s1    <= {NUM_BTN{1'b0}};
      r_s2    <= {NUM_BTN{1'b0}};
      r_level <= {NUM_BTN{1'b0}};
      r_pulse <= {NUM_BTN{1'b0}};
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        r_dcnt[i]  <= {CNT_W{1'b0}};
        r_hcnt[i]  <= {CNT_W{1'b0}};
        r_state[i] <= ST_IDLE;
      end
    end else begin
      r_s1    <= btn_raw;
      r_s2    <= r_s1;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        r_dcnt[i]  <= w_dcnt_nxt[i];
        r_hcnt[i]  <= w_hcnt_nxt[i];
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  assign btn_level = r_level;
  assign btn_pulse = r_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

  logic       clk;
  logic       clr;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] pls;
    int         n;
  } vec_t;

  vec_t tbl [0:11];

  button_conditioner #(
    .NUM_BTN        (3),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5),
    .REPEAT_MASK    (3'b010),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] el, input logic [2:0] ep);
    total_cnt++;
    if (btn_level === el && btn_pulse === ep) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s @%0t: level=%b pulse=%b, expected level=%b pulse=%b",
               name, $time, btn_level, btn_pulse, el, ep);
    end
  endtask

  task automatic step(input string name, input logic [2:0] raw,
                      input logic [2:0] el, input logic [2:0] ep);
    btn_raw = raw;
    @(posedge clk);
    #1;
    check(name, el, ep);
  endtask

  // inc held from edge 1, raw dropped before edge rel; press pulse at edge 6
  task automatic run_inc(input string name, input int rel, input int n);
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] pls;
    for (int e = 1; e <= n; e++) begin
      raw = (e < rel) ? 3'b010 : 3'b000;
      lvl = (e >= 6 && e < rel + 5) ? 3'b010 : 3'b000;
      pls = (e == 6 || (e >= 26 && e < rel + 5 && (e - 26) % 5 == 0)) ? 3'b010 : 3'b000;
      step(name, raw, lvl, pls);
    end
  endtask

  initial begin
    logic [2:0] lvl;
    logic [2:0] pls;

    clr     = 1'b0;
    btn_raw = 3'b111;

    // all buttons held while clr is low
    for (int k = 0; k < 4; k++) step("reset_hold", 3'b111, 3'b000, 3'b000);
    clr = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      lvl = (e >= 6) ? 3'b111 : 3'b000;
      pls = (e == 6) ? 3'b111 : ((e == 26) ? 3'b010 : 3'b000);
      step("reset_release", 3'b111, lvl, pls);
    end
    // release everything: inc still ticks at original edge 31, level falls 6 edges later
    for (int e = 1; e <= 12; e++) begin
      lvl = (e < 6) ? 3'b111 : 3'b000;
      pls = (e == 4) ? 3'b010 : 3'b000;
      step("release_all", 3'b000, lvl, pls);
    end

    tbl[0]  = '{raw: 3'b001, lvl: 3'b000, pls: 3'b000, n: 5};
    tbl[1]  = '{raw: 3'b001, lvl: 3'b001, pls: 3'b001, n: 1};
    tbl[2]  = '{raw: 3'b001, lvl: 3'b001, pls: 3'b000, n: 35};
    tbl[3]  = '{raw: 3'b101, lvl: 3'b001, pls: 3'b000, n: 3};
    tbl[4]  = '{raw: 3'b001, lvl: 3'b001, pls: 3'b000, n: 6};
    tbl[5]  = '{raw: 3'b101, lvl: 3'b001, pls: 3'b000, n: 2};
    tbl[6]  = '{raw: 3'b001, lvl: 3'b001, pls: 3'b000, n: 1};
    tbl[7]  = '{raw: 3'b101, lvl: 3'b001, pls: 3'b000, n: 5};
    tbl[8]  = '{raw: 3'b101, lvl: 3'b101, pls: 3'b100, n: 1};
    tbl[9]  = '{raw: 3'b101, lvl: 3'b101, pls: 3'b000, n: 30};
    tbl[10] = '{raw: 3'b000, lvl: 3'b101, pls: 3'b000, n: 5};
    tbl[11] = '{raw: 3'b000, lvl: 3'b000, pls: 3'b000, n: 5};

    for (int v = 0; v < 12; v++) begin
      for (int k = 0; k < tbl[v].n; k++) begin
        step($sformatf("table[%0d]", v), tbl[v].raw, tbl[v].lvl, tbl[v].pls);
      end
    end

    // level falls on edge 46, which is also a repeat tick: no pulse allowed
    run_inc("release_on_tick", 41, 55);
    // FSM must be back in IDLE: fresh press pulse then normal repeats
    run_inc("inc_repeat", 38, 55);

    // reset in the middle of the hold phase
    run_inc("pre_reset_hold", 1000, 22);
    clr = 1'b0;
    #1;
    check("reset_async", 3'b000, 3'b000);
    for (int k = 0; k < 3; k++) step("reset_mid", 3'b010, 3'b000, 3'b000);
    clr = 1'b1;
    run_inc("after_reset", 32, 45);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
